// File: rtl/debug_tx_serializer.sv
// Purpose: serializes size+1 bytes of a captured debug response word onto a UART line, LSB byte first.
// Latency: first start bit one cycle after start is accepted; done after (size+1) frames of CLKS_PER_BIT-cycle bits.
// Backpressure: none; start is only honoured in IDLE, and start while busy is dropped.
// Optional macro DEBUG_TX_PARITY_EN: inserts an even-parity bit after the data bits (8E1 instead of 8N1).
module debug_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  byte_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [31:0]      word_q;
  logic [1:0]       size_q;
  logic [1:0]       byte_idx_q;

  logic             baud_end;
  logic             last_byte;
  logic [7:0]       cur_byte;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign last_byte = (byte_idx_q == size_q);
  // Byte currently being framed, selected from the word captured at acceptance.
  assign cur_byte  = word_q[{byte_idx_q, 3'b000} +: 8];
  assign byte_idx  = byte_idx_q;

  // State register; reset forces IDLE so tx returns high without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: every non-idle state lasts exactly one bit period per bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        if (baud_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_end && (bit_q == 3'd7)) begin
`ifdef DEBUG_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef DEBUG_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_end) state_d = last_byte ? S_IDLE : S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture on acceptance, baud/bit counting and shifting while framing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      size_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      // The baud counter only runs while a frame is on the line.
      if (state_q != S_IDLE) begin
        baud_q <= baud_end ? '0 : baud_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            word_q     <= result;
            size_q     <= size;
            byte_idx_q <= '0;
            baud_q     <= '0;
          end
        end
        S_START: begin
          if (baud_end) begin
            shift_q <= cur_byte;
            bit_q   <= '0;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
          end
        end
        S_STOP: begin
          // Next byte follows immediately, no idle gap.
          if (baud_end && !last_byte) byte_idx_q <= byte_idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: line level per state; done/busy handoff happens in the final stop-bit cycle.
  always_comb begin
    tx   = 1'b1;
    done = 1'b0;
    busy = (state_q != S_IDLE);
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
`ifdef DEBUG_TX_PARITY_EN
      S_PARITY: tx = ^cur_byte;
`endif
      S_STOP: begin
        if (baud_end && last_byte) begin
          done = 1'b1;
          busy = 1'b0;
        end
      end
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_debug_tx_serializer.sv
module tb_debug_tx_serializer;

  localparam int C = 4;
`ifdef DEBUG_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] result;
  logic [1:0]  size;
  logic        tx;
  logic        busy;
  logic        done;
  logic [1:0]  byte_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debug_tx_serializer #(
    .CLKS_PER_BIT(C),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .result(result),
    .size(size),
    .tx(tx),
    .busy(busy),
    .done(done),
    .byte_idx(byte_idx)
  );

  // Called at the negedge of the first start-bit cycle; checks every cycle up to and
  // including the done cycle against the frame model, returns at the following negedge.
  task automatic check_transfer(input logic [31:0] w, input logic [1:0] s, input bit perturb,
                                output int done_at, output logic [FB-1:0] first_frame);
    bit exp_bits[$];
    int len;
    exp_bits = {};
    for (int b = 0; b <= int'(s); b++) begin
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(w[8*b+i]);
`ifdef DEBUG_TX_PARITY_EN
      exp_bits.push_back(^w[8*b +: 8]);
`endif
      exp_bits.push_back(1'b1);
    end
    len = exp_bits.size() * C;
    done_at = 0;
    first_frame = '0;
    for (int c = 0; c < len; c++) begin
      logic [4:0] got;
      logic [4:0] want;
      got  = {tx, busy, done, byte_idx};
      want = {exp_bits[c/C], (c != len-1), (c == len-1), 2'(c / (FB*C))};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL frame cyc=%0d word=%h size=%0d tx/busy/done/idx got=%b expected=%b",
                 c, w, s, got, want);
      end
      if (c < FB*C && (c % C) == C/2) first_frame[c/C] = tx;
      if (done === 1'b1 && done_at == 0) done_at = c + 1;
      if (perturb && c == 2*C) begin
        start  = 1'b1;
        result = 32'h0;
        size   = 2'd3;
      end
      if (perturb && c == 2*C + 1) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [31:0] w, input logic [1:0] s);
    start  = 1'b1;
    result = w;
    size   = s;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic check_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL %s idle cyc=%0d tx/busy/done got=%b expected=100", tag, i, {tx, busy, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    start  = 1'b0;
    result = 32'h0;
    size   = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx, busy, done, byte_idx} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_values got=%b expected=10000", {tx, busy, done, byte_idx});
    end
    check_quiet(100, "reset");
  endtask

  task automatic test_single_byte();
    int d;
    logic [FB-1:0] f;
    logic [FB-1:0] want_f;
`ifdef DEBUG_TX_PARITY_EN
    want_f = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    want_f = {1'b1, 8'hA5, 1'b0};
`endif
    launch(32'h000000A5, 2'd0);
    check_transfer(32'h000000A5, 2'd0, 1'b0, d, f);
    checks++;
    if (f !== want_f) begin
      errors++;
      $display("FAIL a5_line got=%b expected=%b", f, want_f);
    end
    checks++;
    if (d !== FB*C) begin
      errors++;
      $display("FAIL a5_done_time got=%0d expected=%0d", d, FB*C);
    end
    check_quiet(5, "a5");
  endtask

  task automatic test_four_bytes();
    int d;
    int want_d;
    logic [FB-1:0] f;
`ifdef DEBUG_TX_PARITY_EN
    want_d = 176;
`else
    want_d = 160;
`endif
    launch(32'h12345678, 2'd3);
    check_transfer(32'h12345678, 2'd3, 1'b0, d, f);
    checks++;
    if (d !== want_d) begin
      errors++;
      $display("FAIL four_done_time got=%0d expected=%0d", d, want_d);
    end
    check_quiet(5, "four");
  endtask

  task automatic test_ignore_start();
    int d;
    logic [FB-1:0] f;
    launch(32'hDEADBEEF, 2'd1);
    check_transfer(32'hDEADBEEF, 2'd1, 1'b1, d, f);
    check_quiet(30, "ignore");
  endtask

  task automatic test_back_to_back();
    int d;
    logic [FB-1:0] f;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [1:0] s1;
    logic [1:0] s2;
    w1 = $urandom;
    w2 = $urandom;
    s1 = 2'($urandom_range(0, 3));
    s2 = 2'($urandom_range(0, 3));
    start  = 1'b1;
    result = w1;
    size   = s1;
    @(negedge clk);
    check_transfer(w1, s1, 1'b0, d, f);
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_gap got=%b expected=100", {tx, busy, done});
    end
    result = w2;
    size   = s2;
    @(negedge clk);
    start = 1'b0;
    check_transfer(w2, s2, 1'b0, d, f);
    check_quiet(5, "b2b");
  endtask

  task automatic test_reset_mid();
    int d;
    logic [FB-1:0] f;
    launch($urandom, 2'd2);
    repeat (FB*C + 2*C - 1) @(negedge clk);
    checks++;
    if ({busy, byte_idx} !== 3'b101) begin
      errors++;
      $display("FAIL mid_position busy/idx got=%b expected=101", {busy, byte_idx});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx, busy, done, byte_idx} !== 5'b10000) begin
      errors++;
      $display("FAIL async_reset got=%b expected=10000", {tx, busy, done, byte_idx});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_quiet(20, "post_reset");
    launch(32'h00000055, 2'd0);
    check_transfer(32'h00000055, 2'd0, 1'b0, d, f);
    checks++;
    if (d !== FB*C) begin
      errors++;
      $display("FAIL after_reset_done got=%0d expected=%0d", d, FB*C);
    end
  endtask

  task automatic test_random();
    int d;
    logic [FB-1:0] f;
    logic [31:0] w;
    logic [1:0] s;
    for (int n = 0; n < 10; n++) begin
      w = $urandom;
      s = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      launch(w, s);
      check_transfer(w, s, 1'b0, d, f);
      checks++;
      if (d !== (int'(s) + 1) * FB * C) begin
        errors++;
        $display("FAIL random_done_time n=%0d got=%0d expected=%0d", n, d, (int'(s) + 1) * FB * C);
      end
    end
  endtask

`ifdef DEBUG_TX_PARITY_EN
  task automatic test_parity();
    int d;
    logic [FB-1:0] f;
    launch(32'h00000007, 2'd0);
    check_transfer(32'h00000007, 2'd0, 1'b0, d, f);
    checks++;
    if (f[9] !== 1'b1 || d !== 44) begin
      errors++;
      $display("FAIL parity_07 bit got=%b expected=1 done got=%0d expected=44", f[9], d);
    end
    launch(32'h00000003, 2'd0);
    check_transfer(32'h00000003, 2'd0, 1'b0, d, f);
    checks++;
    if (f[9] !== 1'b0) begin
      errors++;
      $display("FAIL parity_03 bit got=%b expected=0", f[9]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_four_bytes();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DEBUG_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/debug_tx_serializer.md
Name: debug_tx_serializer

Overview:
- Downstream consumer of the debugger decoder's `result[31:0]` and `size[1:0]`.
- Captures one response word on `start` and transmits `size+1` bytes, least-significant byte first, as standard 8N1 UART frames on `tx`.
- Signals completion to the debug command controller.
- Sits between the decoder and the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- CNT_W, 16, width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- result  in  32  response word from the debugger decoder.
- size  in  2  byte count minus one (0 → 1 byte … 3 → 4 bytes).
- tx  out  1  UART serial line; idle high.
- busy  out  1  high from the cycle after `start` is accepted until the last stop bit ends.
- done  out  1  one-cycle pulse when the full response has been sent.
- byte_idx  out  2  index of the byte currently on the line (0 = result[7:0]).

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low.
  - Clock and reset ports are named `clk` and `reset`.
- Reset values:
  - tx=1, busy=0, done=0, byte_idx=0.
  - FSM=IDLE; bit counter, baud counter, shift register and captured word/size all 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - When start=1: latch result→word_q and size→size_q, clear byte_idx and the baud counter, go to START.
  - busy rises the next cycle.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - Load shift register with word_q[8*byte_idx +: 8].
  - Then go to DATA with bit counter = 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles per bit.
  - At each bit-period end, shift right and increment the bit counter.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At period end, if byte_idx == size_q: assert done for one cycle, drop busy in the same cycle, go to IDLE.
  - Otherwise increment byte_idx and go to START. There is no idle gap between bytes.
- Latency:
  - The first start-bit edge appears on tx one cycle after start is accepted.
  - Total frame time is (size_q+1) × 10 × CLKS_PER_BIT cycles, measured from the first tx low to done.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Wraps to 0 at each bit boundary.
  - Never free-runs in IDLE.
- Boundary conditions:
  - start while busy=1 is ignored; word_q and size_q stay stable for the whole transfer.
  - Changes to result/size after acceptance do not affect the bytes sent.
  - start asserted in the same cycle done pulses is ignored, because the FSM is still in STOP. It is accepted in the following cycle if still high.
  - start held high continuously causes back-to-back transfers with exactly one idle-high cycle between them.
  - Reset mid-frame: tx returns to 1 immediately (asynchronously), no done pulse, FSM=IDLE.
  - size=3 sends all four bytes; byte_idx never exceeds size_q.

Optional Feature:
- DEBUG_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx carries the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 8E1; total time is (size_q+1) × 11 × CLKS_PER_BIT.
- Undefined:
  - No PARITY state; 8N1 framing as above.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset: reset=0 for 3 cycles, release → tx=1, busy=0, done=0, byte_idx=0, no tx activity for 100 cycles.
- start with result=32'h000000A5, size=0 → line shows start 0, bits 1,0,1,0,0,1,0,1, stop 1. done pulses once, exactly 40 cycles after the first tx low.
- start with result=32'h12345678, size=3 → bytes 78,56,34,12 in order, byte_idx stepping 0..3. done pulses once at cycle 160 after the first tx low.
- start with result=32'hDEADBEEF, size=1, then result=0 and a second start pulse mid-byte-0 → only EF, BE transmitted, no second transfer, busy stays high throughout.
- Reset asserted during DATA of byte 1 in a size=2 transfer → tx=1 asynchronously, busy=0, no done. A new start with 32'h55 then completes normally.
- With DEBUG_TX_PARITY_EN defined: result=32'h07, size=0 → parity bit 1, done 44 cycles after the first tx low. With result=32'h03 → parity bit 0.
